vga_timing: RTL and testbench
=============================

# vga_timing

Generates 640x480 @ 60 Hz VGA raster timing from the ~25 MHz pixel clock. Sits directly upstream of every background generator and overlay (including the text overlay) and feeds them the current pixel coordinate, active-video flag, and per-frame animation strobe. It also drives the hsync/vsync pins that are registered alongside the final RGB.

## Interface
Parameters (all in pixel clocks or lines):
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width
- `V_BACK`, 33, vertical back porch

Ports:
- `clk`  in  1  pixel clock; one clock domain only
- `rst`  in  1  reset; synchronous, active-high
- `x`  out  10  current column, 0..H_TOTAL-1
- `y`  out  10  current line, 0..V_TOTAL-1
- `active`  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `next_frame`  out  1  one-cycle strobe at the start of vertical blanking
- `frame_count`  out  8  frame counter; see Configuration

## Operation
- H_TOTAL = sum of H_* = 800. V_TOTAL = sum of V_* = 525. Both totals must be ≤ 1024; the counters are 10 bits.
- Horizontal counter `h` increments every clock. When h == H_TOTAL-1:
  - `h` wraps to 0.
  - Vertical counter `v` increments, or wraps to 0 when v == V_TOTAL-1.
- `x = h`, `y = v`, taken directly from the counter registers.
- The remaining outputs are registered and decoded from the next-state counter values, so they are coherent with `x`/`y` in the same cycle:
  - `active` = (h < H_ACTIVE) && (v < V_ACTIVE).
  - `hsync` = 0 iff H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC (656..751), else 1.
  - `vsync` = 0 iff V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC (490..491), else 1. vsync transitions coincide with h == 0.
  - `next_frame` = 1 iff h == 0 && v == V_ACTIVE (480). That is exactly one cycle per frame, during blanking, so consumers update animation state before the next visible line 0.
- No other states: the block is a free-running pair of counters.

## Timing
- Reset (`rst` high at a clock edge) forces:
  - h = 0, v = 0
  - `x` = 0, `y` = 0
  - `active` = 1, `hsync` = 1, `vsync` = 1
  - `next_frame` = 0, `frame_count` = 0
- Counting resumes on the first edge with `rst` low. The first cycle after reset shows (0,0); the next shows (1,0).
- Reset mid-frame aborts the line immediately with no partial sync pulse carried over. A `next_frame` already high drops to 0 on the reset edge.
- Line period is 800 clocks and frame period is 420 000 clocks.
- `next_frame` spacing is exactly 420 000 clocks in steady state.
- Zero latency between `x`/`y` and the decoded outputs: all change on the same edge.
- Line and frame wrap coincide at (799,524) → (0,0): both counters reset on the same edge.

## Configuration
- `VGA_FRAME_COUNTER_EN` defined:
  - `frame_count` increments by 1 on the same edge that `next_frame` rises.
  - It wraps 255 → 0 and is cleared by `rst`.
- Not defined:
  - `frame_count` is tied to 8'd0.
  - No counter flops are synthesised; the port remains present so the top-level wiring is unchanged.

## Test plan
- Reset then run 2 lines:
  - cycle 0 → x=0, y=0, active=1.
  - x=639 → active=1; x=640 → active=0.
  - x=799 → y=0; next cycle x=0, y=1.
- hsync window: on line 5, hsync=1 at x=655; hsync=0 from x=656 through x=751; hsync=1 at x=752.
- Frame wrap and vsync:
  - vsync=0 only on y=490 and y=491, asserting and deasserting at x=0.
  - (799,524) → (0,0).
  - active=0 for every y ≥ 480.
- next_frame: run 3 frames; exactly 3 one-cycle pulses, each at (x=0, y=480), spaced 420 000 clocks apart.
- Reset mid-frame: assert `rst` for 1 cycle at (x=300, y=200) → next outputs x=0, y=0, hsync=1, vsync=1; the next next_frame arrives 480×800 = 384 000 clocks after reset release.
- With `VGA_FRAME_COUNTER_EN`: run 257 frames → `frame_count` reads 1 after the 257th strobe. Without the macro → `frame_count` stays 0 throughout.

Source files
------------

// File: rtl/vga_timing.sv
// 640x480 @ 60 Hz VGA raster timing: free-running pixel/line counters plus registered decodes.
// Optional VGA_FRAME_COUNTER_EN adds an 8-bit frame counter on frame_count; otherwise it is tied to zero.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       next_frame,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Decode bounds are 11 bits so a sync window ending exactly at 1024 still compares correctly.
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYN_BEG = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_SYN_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYN_BEG = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] V_SYN_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing: line/frame totals exceed the 10-bit counters");
    end

    function automatic logic in_window(input logic [9:0] val,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return ({1'b0, val} >= lo) && ({1'b0, val} < hi);
    endfunction

    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       active_nxt;
    logic       hsync_nxt;
    logic       vsync_nxt;
    logic       nf_nxt;

    always_comb begin
        h_nxt = h + 10'd1;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = 10'd0;
            v_nxt = (v == V_LAST) ? 10'd0 : v + 10'd1;
        end
    end

    // Decode from the next counter values so the registered flags line up with x/y.
    always_comb begin
        active_nxt = ({1'b0, h_nxt} < H_ACT_END) && ({1'b0, v_nxt} < V_ACT_END);
        hsync_nxt  = !in_window(h_nxt, H_SYN_BEG, H_SYN_END);
        vsync_nxt  = !in_window(v_nxt, V_SYN_BEG, V_SYN_END);
        nf_nxt     = (h_nxt == 10'd0) && ({1'b0, v_nxt} == V_ACT_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h          <= 10'd0;
            v          <= 10'd0;
            active     <= 1'b1;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            next_frame <= 1'b0;
        end else begin
            h          <= h_nxt;
            v          <= v_nxt;
            active     <= active_nxt;
            hsync      <= hsync_nxt;
            vsync      <= vsync_nxt;
            next_frame <= nf_nxt;
        end
    end

    assign x = h;
    assign y = v;

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] frame_cnt;

    // Advances on the same edge that raises next_frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (nf_nxt) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign frame_count = frame_cnt;
`else
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance and a shrunken-timing instance share clk/rst,
// each scoreboarded every cycle against a model built from the elapsed-cycle count.
module tb_vga_timing;

    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 6, SVF = 2, SVS = 2, SVB = 2;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SF  = SHT * (SVA + SVF + SVS + SVB);

    typedef logic [31:0] vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_d, y_d, x_s, y_s;
    logic       act_d, hs_d, vs_d, nf_d, act_s, hs_s, vs_s, nf_s;
    logic [7:0] fc_d, fc_s;

    always #5 clk = ~clk;

    vga_timing u_vga (
        .clk(clk), .rst(rst), .x(x_d), .y(y_d), .active(act_d), .hsync(hs_d),
        .vsync(vs_d), .next_frame(nf_d), .frame_count(fc_d)
    );

    vga_timing #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) u_small (
        .clk(clk), .rst(rst), .x(x_s), .y(y_s), .active(act_s), .hsync(hs_s),
        .vsync(vs_s), .next_frame(nf_s), .frame_count(fc_s)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   t       = 0;
    bit   armed   = 1'b0;
    vec_t q_s[$];
    vec_t q_d[$];
    int   pulses[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Expected outputs t edges after the last reset edge, from division rather than counters.
    function automatic vec_t model(input int tt, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb);
        int ht, vt, px, py;
        logic a, hsn, vsn, nf;
        logic [7:0] fc;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        px  = tt % ht;
        py  = (tt / ht) % vt;
        a   = (px < ha) && (py < va);
        hsn = !((px >= ha + hf) && (px < ha + hf + hs));
        vsn = !((py >= va + vf) && (py < va + vf + vs));
        nf  = (px == 0) && (py == va);
        fc  = 8'd0;
`ifdef VGA_FRAME_COUNTER_EN
        if (tt >= va * ht) fc = 8'((tt - va * ht) / (ht * vt) + 1);
`endif
        return {px[9:0], py[9:0], a, hsn, vsn, nf, fc};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t     = 0;
            armed = 1'b1;
        end else if (armed) begin
            t = t + 1;
        end
        if (armed) begin
            q_s.push_back(model(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
            q_d.push_back(model(t, 640, 16, 96, 48, 480, 10, 2, 33));
        end
    end

    always @(negedge clk) begin
        if (q_s.size() != 0) begin
            check("sb_small", {x_s, y_s, act_s, hs_s, vs_s, nf_s, fc_s}, q_s.pop_front());
            check("sb_vga", {x_d, y_d, act_d, hs_d, vs_d, nf_d, fc_d}, q_d.pop_front());
            if (nf_s) pulses.push_back(t);
        end
    end

    task automatic run(input int n, input logic r);
        rst = r;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pulses(input string tag, input int n_exp);
        check({tag, "_count"}, pulses.size(), n_exp);
        if (pulses.size() > 0) check({tag, "_first"}, pulses[0], SVA * SHT);
        for (int i = 1; i < pulses.size(); i++)
            check({tag, "_gap"}, pulses[i] - pulses[i-1], SF);
    endtask

    initial begin
        logic [7:0] fc_exp;
        @(negedge clk);
        run(2, 1'b1);
        #1;
        check("rst_x", x_s, 0);
        check("rst_flags", {act_s, hs_s, vs_s, nf_s}, 4'b1110);

        // Three frames from reset release.
        pulses.delete();
        run(3 * SF - 1, 1'b0);
        #1;
        check_pulses("nf3", 3);

        // Mid-frame reset at (5,3) of the small raster.
        pulses.delete();
        run(3 * SHT + 6, 1'b0);
        #1;
        check("pre_rst_xy", {x_s, y_s}, {10'd5, 10'd3});
        run(1, 1'b1);
        #1;
        check("mid_rst_out", {x_s, y_s, hs_s, vs_s, nf_s}, {20'd0, 3'b110});
        check("mid_rst_vga", {x_d, y_d, hs_d, vs_d}, {20'd0, 2'b11});

        // 257 frames after the reset; frame_count wraps to 1 when enabled.
        pulses.delete();
        run(SVA * SHT + 256 * SF + 10, 1'b0);
        #1;
        check_pulses("nf257", 257);
`ifdef VGA_FRAME_COUNTER_EN
        fc_exp = 8'd1;
`else
        fc_exp = 8'd0;
`endif
        check("fc257", fc_s, fc_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
